// File: rtl/branch_resolver_pkg.sv
// Shared types for the execute-stage branch resolver: word width, NZCV flags,
// ARM condition codes and resolver FSM states.
package branch_resolver_pkg;

  localparam int WORD = 32;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } status_register;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_code;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } branch_resolve_state;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational ARM condition evaluator: condition code + NZCV -> taken.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  cond_code       cond,
  input  status_register flags,
  output logic           taken
);

  logic n, z, c, v;

  assign n = flags.negative;
  assign z = flags.zero;
  assign c = flags.carry;
  assign v = flags.overflow;

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c & !z;
      COND_LS: taken = !c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: registered redirect pulse plus wrong-path squash.
// Optional resolve/taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             is_valid_i,
  input  logic             is_branch_i,
  input  logic             is_cond_i,
  input  logic [3:0]       cond_i,
  input  status_register   status_reg_i,
  input  logic [WORD-1:0]  target_i,
  output logic             redirect_valid_o,
  output logic [WORD-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic [WORD-1:0]  branch_count_o,
  output logic [WORD-1:0]  taken_count_o
);

  branch_resolve_state state;
  logic [3:0]          flush_cnt;
  logic                cond_true;
  logic                resolve;
  logic                taken;

  cond_eval u_cond_eval (
    .cond  (cond_code'(cond_i)),
    .flags (status_reg_i),
    .taken (cond_true)
  );

  // Branches seen while squashing are wrong-path and must never resolve.
  assign resolve = is_valid_i & is_branch_i & (state == ST_IDLE);
  assign taken   = resolve & (!is_cond_i | cond_true);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state            <= ST_IDLE;
      flush_cnt        <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          redirect_valid_o <= 1'b0;
          flush_o          <= 1'b0;
          if (taken) begin
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= {target_i[WORD-1:1], 1'b0};
            flush_o          <= 1'b1;
            flush_cnt        <= 4'(FLUSH_CYCLES - 1);
            state            <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          redirect_valid_o <= 1'b0;
          if (flush_cnt == 4'd0) begin
            flush_o <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            flush_o   <= 1'b1;
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          redirect_valid_o <= 1'b0;
          flush_o          <= 1'b0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [WORD-1:0] branch_count_reg;
  logic [WORD-1:0] taken_count_reg;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      branch_count_reg <= '0;
      taken_count_reg  <= '0;
    end else begin
      if (resolve) branch_count_reg <= branch_count_reg + 1'b1;
      if (taken)   taken_count_reg  <= taken_count_reg + 1'b1;
    end
  end

  assign branch_count_o = branch_count_reg;
  assign taken_count_o  = taken_count_reg;
`else
  assign branch_count_o = '0;
  assign taken_count_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (FLUSH_CYCLES=2).
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            is_valid;
  logic            is_branch;
  logic            is_cond;
  logic [3:0]      cond;
  status_register  status_reg;
  logic [WORD-1:0] target;
  logic            redirect_valid;
  logic [WORD-1:0] redirect_pc;
  logic            flush;
  logic [WORD-1:0] branch_count;
  logic [WORD-1:0] taken_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolver #(.FLUSH_CYCLES(2)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .is_valid_i       (is_valid),
    .is_branch_i      (is_branch),
    .is_cond_i        (is_cond),
    .cond_i           (cond),
    .status_reg_i     (status_reg),
    .target_i         (target),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .flush_o          (flush),
    .branch_count_o   (branch_count),
    .taken_count_o    (taken_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present inputs for one cycle, then sample #1 after the edge.
  task automatic step(input logic v, input logic b, input logic c, input logic [3:0] cc,
                      input logic [3:0] nzcv, input logic [31:0] tgt);
    is_valid   = v;
    is_branch  = b;
    is_cond    = c;
    cond       = cc;
    status_reg = nzcv;
    target     = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  // Hand-written condition table, flags packed as {N,Z,C,V}.
  function automatic logic ref_taken(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    is_valid = 0; is_branch = 0; is_cond = 0; cond = 0; status_reg = '0; target = 0;

    // Reset state
    idle_cycle();
    idle_cycle();
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_tcnt", taken_count, 32'd0);
    reset_n = 1'b1;
    idle_cycle();
    $display("txn reset: redirect=%0b flush=%0b pc=%h", redirect_valid, flush, redirect_pc);

    // BEQ, Z=1, target 0x1003
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'b0100, 32'h0000_1003);
    $display("txn beq: redirect=%0b pc=%h flush=%0b", redirect_valid, redirect_pc, flush);
    chk("beq_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("beq_pc", redirect_pc, 32'h0000_1002);
    chk("beq_flush0", {31'd0, flush}, 32'd1);
    idle_cycle();
    chk("beq_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    idle_cycle();
    chk("beq_flush_drop", {31'd0, flush}, 32'd0);
    chk("beq_pc_hold", redirect_pc, 32'h0000_1002);

    // Not-taken branch and invalid branch leave outputs idle
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 32'h0000_2000);
    $display("txn beq_nt: redirect=%0b flush=%0b", redirect_valid, flush);
    chk("nt_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("nt_pc_hold", redirect_pc, 32'h0000_1002);
    step(1'b0, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_3000);
    $display("txn invalid_b: redirect=%0b flush=%0b", redirect_valid, flush);
    chk("inv_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("inv_flush", {31'd0, flush}, 32'd0);

    // Sweep all conditions over all flag values
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        logic exp_t;
        exp_t = ref_taken(4'(cc), 4'(f));
        step(1'b1, 1'b1, 1'b1, 4'(cc), 4'(f), 32'h0000_4000 + 32'(cc * 16 + f) * 4);
        chk($sformatf("sweep_c%0d_f%0d", cc, f), {31'd0, redirect_valid}, {31'd0, exp_t});
        if (redirect_valid) begin
          idle_cycle();
          idle_cycle();
        end
      end
    end
    $display("txn sweep: 256 condition/flag combinations applied");

    // Unconditional branch with NV field: is_cond=0 means AL
    step(1'b1, 1'b1, 1'b0, 4'd15, 4'b0000, 32'h0000_5001);
    $display("txn b_uncond: redirect=%0b pc=%h", redirect_valid, redirect_pc);
    chk("uncond_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("uncond_pc", redirect_pc, 32'h0000_5000);
    idle_cycle();
    idle_cycle();

    // Back-to-back: BNE taken, then B at t+1, t+2 squashed, B at t+3 resolves
    step(1'b1, 1'b1, 1'b1, 4'd1, 4'b0000, 32'h0000_6000);
    chk("b2b_t0_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("b2b_t0_pc", redirect_pc, 32'h0000_6000);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_7000);
    chk("b2b_t1_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("b2b_t1_flush", {31'd0, flush}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_8000);
    chk("b2b_t2_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("b2b_t2_pc", redirect_pc, 32'h0000_6000);
    chk("b2b_t2_flush", {31'd0, flush}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_9000);
    $display("txn b2b_t3: redirect=%0b pc=%h", redirect_valid, redirect_pc);
    chk("b2b_t3_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("b2b_t3_pc", redirect_pc, 32'h0000_9000);

    // Reset held two cycles mid-FLUSH
    reset_n = 1'b0;
    idle_cycle();
    idle_cycle();
    $display("txn reset_mid_flush: redirect=%0b flush=%0b pc=%h", redirect_valid, flush, redirect_pc);
    chk("mrst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("mrst_flush", {31'd0, flush}, 32'd0);
    chk("mrst_pc", redirect_pc, 32'd0);
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_A000);
    chk("mrst_idle_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("mrst_idle_pc", redirect_pc, 32'h0000_A000);
    idle_cycle();
    idle_cycle();

    // Statistics: 5 resolves, 3 taken, 2 branches squashed in FLUSH
    reset_n = 1'b0;
    idle_cycle();
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 32'h0000_B000);
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'b0100, 32'h0000_B100);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_B200);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_B300);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_B400);
    chk("stat_last_pc", redirect_pc, 32'h0000_B400);
    idle_cycle();
    idle_cycle();
    step(1'b1, 1'b1, 1'b1, 4'd1, 4'b0100, 32'h0000_B500);
    step(1'b1, 1'b1, 1'b0, 4'd14, 4'b0000, 32'h0000_B600);
    idle_cycle();
    idle_cycle();
    $display("txn stats: branch_count=%0d taken_count=%0d", branch_count, taken_count);
`ifdef BRANCH_STATS_EN
    chk("stat_bcnt", branch_count, 32'd5);
    chk("stat_tcnt", taken_count, 32'd3);
`else
    chk("stat_bcnt_off", branch_count, 32'd0);
    chk("stat_tcnt_off", taken_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
